sccb_reg_config: RTL and testbench
==================================

// Module: sccb_reg_config
// PURPOSE
//  Upstream sequencer for the SCCB write controller. Divides the 25 MHz system clock into the 100 kHz
//  SCCB bit clock plus a one-cycle falling-edge strobe, waits a power-up delay, then walks a register
//  table. For each entry it presents a 24-bit {dev_id, sub_addr, value} word, pulses the controller
//  enable, and waits for transfer-finished. Raises config_done once the whole table is written.
// PARAMETERS
//  CLK_DIV_HALF   125    system clocks per half SCCB bit period (25 MHz / 125 / 2 = 100 kHz)
//  LUT_SIZE       200    number of table entries, indices 0..LUT_SIZE-1 (<=256)
//  POWERUP_TICKS  20000  strobe ticks to wait after reset before first write (~200 ms)
//  GAP_TICKS      4      strobe ticks with enable low between consecutive writes
//  MAX_RETRY      3      retries per entry (SCCB_RETRY_EN only)
// PORTS
//  clk             in   1   system clock, 25 MHz
//  rst_n           in   1   asynchronous active-low reset
//  start           in   1   one-cycle pulse: rerun the whole table (no power-up wait); ignored unless IDLE/DONE
//  sclk_100k       out  1   SCCB bit clock to the controller
//  i2c_negclk      out  1   one-clk strobe in the last high cycle of sclk_100k
//  sccb_en         out  1   controller enable; high for the whole transfer
//  wr_data         out  24  {dev_id[23:16], sub_addr[15:8], value[7:0]}, stable while sccb_en=1
//  trans_finished  in   1   controller end-of-transfer flag
//  ack             in   1   controller ack summary, 0 = all three bytes acked
//  lut_index       out  8   table address
//  lut_data        in   24  table word, registered ROM, valid 1 clk after lut_index changes
//  config_done     out  1   high from table completion until the next start or reset
//  cfg_err         out  1   sticky: an entry exhausted its retries (tied 0 without SCCB_RETRY_EN)
// BEHAVIOUR
//  Reset: all outputs 0, div_cnt=0, state=PWRUP, tick counter=0, lut_index=0.
//  Divider: div_cnt counts 0..2*CLK_DIV_HALF-1, then wraps to 0. sclk_100k=1 while div_cnt<CLK_DIV_HALF.
//   i2c_negclk=1 only when div_cnt==CLK_DIV_HALF-1. Divider free-runs in every state.
//  A "tick" means a clk cycle with i2c_negclk=1. All FSM timing below is counted in ticks unless stated.
//  FSM:
//   PWRUP : count ticks; at POWERUP_TICKS -> LOAD, lut_index=0.
//   LOAD  : wait exactly 2 clk (ROM latency), latch lut_data into wr_data -> WRITE.
//   WRITE : sccb_en=1; on a tick where trans_finished=1 -> GAP, and drop sccb_en in the same clk.
//           Outside ticks, trans_finished is ignored.
//   GAP   : sccb_en=0 for GAP_TICKS ticks. Then, if lut_index==LUT_SIZE-1 -> DONE;
//           else lut_index+1 -> LOAD.
//   DONE  : config_done=1 and sccb_en=0. On start -> LOAD, lut_index=0, config_done=0.
//  start in PWRUP/LOAD/WRITE/GAP: ignored.
//  wr_data never changes while sccb_en=1.
//  lut_index never exceeds LUT_SIZE-1. There is no wrap.
//  Reset asserted mid-transfer: sccb_en drops asynchronously and the FSM restarts in PWRUP with full delay.
//  trans_finished high during GAP or LOAD: ignored (the controller clears it after enable falls).
// CONFIGURATION
//  SCCB_RETRY_EN defined: at the WRITE->GAP tick, sample ack.
//   ack=1 and retry count < MAX_RETRY: retry count+1, same lut_index, GAP then LOAD again.
//   ack=1 and retries exhausted: set cfg_err, then advance normally.
//   Retry count clears whenever the entry advances.
//  SCCB_RETRY_EN undefined: ack is ignored, each entry is written exactly once, cfg_err tied 0.
// TESTING
//  T1 divider: reset then run 1000 clk -> sclk_100k period 250 clk, 125 high.
//     i2c_negclk one clk wide, every 250 clk, at the sclk high->low boundary.
//  T2 power-up: POWERUP_TICKS=10 -> first sccb_en rise 10 ticks + 2 clk after reset release;
//     wr_data = ROM[0] = 24'h42_12_80.
//  T3 sequence: LUT_SIZE=3 with a controller model finishing after 39 ticks.
//     -> 3 transfers, each separated by 4 ticks of sccb_en=0.
//     -> config_done rises after the 3rd GAP. lut_index stops at 2.
//  T4 restart: in DONE pulse start -> config_done falls next clk, lut_index=0, ROM[0] re-sent, no power-up wait.
//     A start pulse during WRITE -> no effect.
//  T5 reset mid-write: drop rst_n during tick 20 of a transfer -> sccb_en=0 immediately.
//     After release, the full power-up delay runs again, then entry 0.
//  T6 (SCCB_RETRY_EN) model returns ack=1 on entry 1 always -> entry 1 sent 4 times, cfg_err=1,
//     entry 2 follows. With the macro undefined -> entry 1 sent once, cfg_err=0.

Source files
------------

// File: rtl/sccb_reg_config.sv
// SCCB register-table sequencer: 100 kHz bit-clock divider, power-up delay, then one controller
// write per table entry. Optional per-entry retry on NACK is enabled by defining SCCB_RETRY_EN.
module sccb_reg_config #(
    parameter int unsigned CLK_DIV_HALF  = 125,
    parameter int unsigned LUT_SIZE      = 200,
    parameter int unsigned POWERUP_TICKS = 20000,
    parameter int unsigned GAP_TICKS     = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        sclk_100k_o,
    output logic        i2c_negclk_o,
    output logic        sccb_en_o,
    output logic [23:0] wr_data_o,
    input  logic        trans_finished_i,
    input  logic        ack_i,
    output logic [7:0]  lut_index_o,
    input  logic [23:0] lut_data_i,
    output logic        config_done_o,
    output logic        cfg_err_o
);

    localparam int unsigned DivW   = $clog2(2 * CLK_DIV_HALF);
    localparam int unsigned CntMax = (POWERUP_TICKS > GAP_TICKS) ? POWERUP_TICKS : GAP_TICKS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StPwrup, StLoad, StWrite, StGap, StDone} state_e;

    logic [DivW-1:0] div_q, div_d;
    logic            sclk_q, negclk_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_q, load_d;
    logic [7:0]      idx_q, idx_d;
    logic [23:0]     wr_q, wr_d;
    logic            advance;
    logic            tick;

`ifdef SCCB_RETRY_EN
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RtyW-1:0] retry_q, retry_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
`else
    logic unused_ack;
    assign unused_ack = ack_i;
`endif

    // Divider outputs are registered from div_d so they line up with div_q after every edge.
    always_comb begin
        div_d = (div_q == DivW'(2 * CLK_DIV_HALF - 1)) ? '0 : div_q + DivW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            sclk_q   <= 1'b0;
            negclk_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            sclk_q   <= (div_d < DivW'(CLK_DIV_HALF));
            negclk_q <= (div_d == DivW'(CLK_DIV_HALF - 1));
        end
    end

    assign tick = negclk_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        idx_d   = idx_q;
        wr_d    = wr_q;
        advance = 1'b1;
`ifdef SCCB_RETRY_EN
        retry_d = retry_q;
        pend_d  = pend_q;
        err_d   = err_q;
        advance = !pend_q;
`endif
        case (state_q)
            StPwrup: begin
                if (tick) begin
                    if (cnt_q == CntW'(POWERUP_TICKS - 1)) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StLoad: begin
                // Second LOAD cycle: registered ROM output now reflects idx_q.
                load_d = !load_q;
                if (load_q) begin
                    wr_d    = lut_data_i;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (tick && trans_finished_i) begin
                    state_d = StGap;
                    cnt_d   = '0;
`ifdef SCCB_RETRY_EN
                    pend_d = 1'b0;
                    if (ack_i) begin
                        if (32'(retry_q) < MAX_RETRY) begin
                            retry_d = retry_q + RtyW'(1);
                            pend_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`endif
                end
            end
            StGap: begin
                if (tick) begin
                    if (cnt_q == CntW'(GAP_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = StLoad;
                        if (advance) begin
`ifdef SCCB_RETRY_EN
                            retry_d = '0;
`endif
                            if (idx_q == 8'(LUT_SIZE - 1)) begin
                                state_d = StDone;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                if (start_i) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StPwrup;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            idx_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
        end
    end

`ifdef SCCB_RETRY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end
    assign cfg_err_o = err_q;
`else
    assign cfg_err_o = 1'b0;
`endif

    // Enable decodes straight from state so a reset clears it without waiting for a clock.
    assign sccb_en_o     = (state_q == StWrite);
    assign config_done_o = (state_q == StDone);
    assign sclk_100k_o   = sclk_q;
    assign i2c_negclk_o  = negclk_q;
    assign wr_data_o     = wr_q;
    assign lut_index_o   = idx_q;

endmodule

// File: tb/tb_sccb_reg_config.sv
// Bench for sccb_reg_config: a task-level reference model of the table walk checked every cycle,
// plus literal timing/ordering checks. Build with SCCB_RETRY_EN defined to cover the retry path.
module tb_sccb_reg_config;

    localparam int unsigned H   = 25;
    localparam int unsigned N   = 3;
    localparam int unsigned P   = 10;
    localparam int unsigned G   = 4;
    localparam int unsigned MR  = 3;
    localparam int unsigned FIN = 39;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, tf = 1'b0, ack = 1'b0;
    logic        sclk, negclk, en, done, err;
    logic [23:0] wr_data, lut_data;
    logic [7:0]  lut_idx;
    logic        sclk2, negclk2, en2, done2, err2;
    logic [23:0] wr2;
    logic [7:0]  idx2;

    logic [23:0] rom [N] = '{24'h421280, 24'h421101, 24'h420c00};

    int tests = 0, fails = 0;
    bit checking = 0;

    always #20 clk = ~clk;

    sccb_reg_config #(
        .CLK_DIV_HALF(H), .LUT_SIZE(N), .POWERUP_TICKS(P), .GAP_TICKS(G), .MAX_RETRY(MR)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sclk_100k_o(sclk), .i2c_negclk_o(negclk),
        .sccb_en_o(en), .wr_data_o(wr_data), .trans_finished_i(tf), .ack_i(ack),
        .lut_index_o(lut_idx), .lut_data_i(lut_data), .config_done_o(done), .cfg_err_o(err)
    );

    sccb_reg_config #(
        .CLK_DIV_HALF(125)
    ) u_div (
        .clk_i(clk), .rst_ni(rst_n), .start_i(1'b0), .sclk_100k_o(sclk2), .i2c_negclk_o(negclk2),
        .sccb_en_o(en2), .wr_data_o(wr2), .trans_finished_i(1'b0), .ack_i(1'b0),
        .lut_index_o(idx2), .lut_data_i(24'h0), .config_done_o(done2), .cfg_err_o(err2)
    );

    always @(posedge clk) lut_data <= (lut_idx < 8'(N)) ? rom[lut_idx[1:0]] : 24'hdead00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller stand-in: finishes on the FIN-th tick of a transfer, NACKs every write of entry 1.
    int ccnt = 0;
    always @(negedge clk) begin
        if (en !== 1'b1) begin
            ccnt = 0; tf = 1'b0; ack = 1'b0;
        end else if (negclk && !tf) begin
            ccnt++;
            if (ccnt == FIN) begin
                tf  = 1'b1;
                ack = (wr_data == rom[1]);
            end
        end
    end

    // Reference model: what the outputs must be in the current cycle (cycle index mcyc).
    logic        m_en = 0, m_done = 0, m_err = 0, m_live = 0;
    logic [7:0]  m_idx = 0;
    logic [23:0] m_wr = 0;
    int          mcyc = 0;
    bit          p_tick, p_tf, p_start, p_ack;

    task automatic adv(output bit ab);
        @(posedge clk or negedge rst_n);
        if (!rst_n) ab = 1;
        else begin
            p_tick  = (mcyc % (2 * H)) == H - 1;
            p_tf    = tf;
            p_start = start;
            p_ack   = ack;
            mcyc++;
            ab = 0;
        end
    endtask

    initial begin : model
        bit ab, retry;
        int t, i, tries;
        forever begin
            m_en = 0; m_done = 0; m_err = 0; m_idx = 0; m_wr = 0; m_live = 0;
            wait (rst_n === 1'b1);
            mcyc = 0; m_live = 1; ab = 0; t = 0;
            while (!ab && t < P) begin adv(ab); if (!ab && p_tick) t++; end
            while (!ab) begin
                i = 0; tries = 0;
                while (!ab) begin
                    m_idx = 8'(i);
                    adv(ab); if (ab) break;
                    adv(ab); if (ab) break;
                    m_en = 1; m_wr = rom[i];
                    do adv(ab); while (!ab && !(p_tick && p_tf));
                    if (ab) break;
                    m_en = 0; retry = 0;
`ifdef SCCB_RETRY_EN
                    if (p_ack) begin
                        if (tries < MR) begin tries++; retry = 1; end
                        else m_err = 1;
                    end
`endif
                    t = 0;
                    while (!ab && t < G) begin adv(ab); if (!ab && p_tick) t++; end
                    if (ab) break;
                    if (!retry) begin
                        tries = 0;
                        if (i == N - 1) break;
                        i++;
                    end
                end
                if (ab) break;
                m_done = 1;
                do adv(ab); while (!ab && !p_start);
                if (ab) break;
                m_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            if (rst_n === 1'b0) begin
                chk("rst sccb_en", en, 0);
                chk("rst config_done", done, 0);
                chk("rst lut_index", lut_idx, 0);
            end else if (m_live) begin
                chk("sccb_en", en, m_en);
                chk("config_done", done, m_done);
                chk("lut_index", lut_idx, m_idx);
                chk("cfg_err", err, m_err);
                if (m_en) chk("wr_data", wr_data, m_wr);
                if (mcyc >= 1) begin
                    chk("sclk_100k", sclk, (mcyc % (2 * H)) < H);
                    chk("i2c_negclk", negclk, (mcyc % (2 * H)) == H - 1);
                    chk("sclk_100k 250", sclk2, (mcyc % 250) < 125);
                    chk("i2c_negclk 250", negclk2, (mcyc % 250) == 124);
                end
                if (mcyc == 124) chk("div negclk at 124", negclk2, 1);
                if (mcyc == 125) chk("div sclk at 125", sclk2, 0);
                if (mcyc == 250) chk("div sclk at 250", sclk2, 1);
                if (mcyc == 374) chk("div negclk at 374", negclk2, 1);
            end
        end
    end

    // Transfer log: cycle of each enable rise/fall and the word presented.
    int          rises[$], falls[$];
    logic [23:0] sent[$];
    logic        en_prev = 0;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) en_prev = 0;
        else begin
            if (en && !en_prev) begin rises.push_back(mcyc); sent.push_back(wr_data); end
            if (!en && en_prev) falls.push_back(mcyc);
            en_prev = en;
        end
    end

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 40000) begin @(negedge clk); k++; end
        chk(name, done, 1);
    endtask

    task automatic wait_rise(input string name);
        int k = 0;
        while (rises.size() == 0 && k < 5000) begin @(negedge clk); k++; end
        chk(name, rises.size() > 0, 1);
    endtask

    task automatic check_words(input string name, input int exp_n);
        logic [23:0] w [$];
        w.push_back(rom[0]);
`ifdef SCCB_RETRY_EN
        repeat (4) w.push_back(rom[1]);
`else
        w.push_back(rom[1]);
`endif
        w.push_back(rom[2]);
        chk({name, " count"}, sent.size(), exp_n);
        for (int k = 0; k < exp_n && k < sent.size(); k++) chk({name, " word"}, sent[k], w[k]);
    endtask

    initial begin : main
        int s, nt, k, exp_n, exp_err;
`ifdef SCCB_RETRY_EN
        exp_n = 6; exp_err = 1;
`else
        exp_n = 3; exp_err = 0;
`endif
        repeat (3) @(negedge clk);
        checking = 1;
        chk("reset sclk", sclk, 0);
        chk("reset negclk", negclk, 0);
        chk("reset wr_data", wr_data, 0);
        chk("reset cfg_err", err, 0);
        #1 rst_n = 1'b1;

        wait_done("first run done");
        if (rises.size() > 0 && falls.size() > 0 && rises.size() > 1) begin
            chk("first enable cycle", rises[0], 477);
            chk("first word", sent[0], 24'h421280);
            chk("write length", falls[0] - rises[0], 1948);
            chk("gap length", rises[1] - falls[0], 202);
        end else chk("transfers logged", rises.size(), exp_n);
        check_words("run1", exp_n);
        chk("index at done", lut_idx, 8'd2);
        chk("cfg_err at done", err, exp_err);

        rises.delete(); falls.delete(); sent.delete();
        @(negedge clk) start = 1'b1;
        s = mcyc;
        @(negedge clk) start = 1'b0;
        chk("done after start", done, 0);
        chk("index after start", lut_idx, 0);
        wait_rise("restart enable");
        if (rises.size() > 0) chk("restart latency", rises[0] - s, 3);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("second run done");
        check_words("run2", exp_n);

        rises.delete(); falls.delete(); sent.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_rise("third run enable");
        nt = 0; k = 0;
        while (nt < 20 && k < 5000) begin @(negedge clk); k++; if (negclk) nt++; end
        chk("tick 20 reached", nt, 20);
        #1 rst_n = 1'b0;
        #1 chk("async enable drop", en, 0);
        chk("async index clear", lut_idx, 0);
        repeat (3) @(negedge clk);
        rises.delete(); falls.delete(); sent.delete();
        #1 rst_n = 1'b1;
        wait_rise("repower enable");
        if (rises.size() > 0) begin
            chk("repower latency", rises[0], 477);
            chk("repower word", sent[0], 24'h421280);
        end
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
